// File: rtl/gpio_sw_debounce.sv
// Switch input conditioner: per-bit synchroniser, stability-counter debounce,
// one-cycle rise/fall pulses and a sticky change mask cleared by an acknowledge.
module gpio_sw_debounce #(
  parameter int unsigned N_SW        = 12,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 65535
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_in,
  output logic [N_SW-1:0] sw_out,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            change_pending,
  output logic [N_SW-1:0] change_mask,
  input  logic            change_ack
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [N_SW-1:0]  sync_q [SYNC_STAGES];
  logic [N_SW-1:0]  sync;
  logic [CNT_W-1:0] cnt_q  [N_SW];
  logic [CNT_W-1:0] cnt_d  [N_SW];
  logic [N_SW-1:0]  sw_out_d;
  logic [N_SW-1:0]  upd;
  logic [N_SW-1:0]  change_mask_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Plain flop chain bringing the asynchronous pins into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= sw_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Per-bit stability counter; any agreement with sw_out restarts the count.
  always_comb begin
    sw_out_d = sw_out;
    upd      = '0;
    for (int i = 0; i < N_SW; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != sw_out[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          sw_out_d[i] = sync[i];
          upd[i]      = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Ack clears old bits, but bits updating in the same cycle survive it.
  always_comb begin
    change_mask_d = (change_ack ? '0 : change_mask) | upd;
  end

  // Register debounced state, edge pulses and change tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SW; i++) begin
        cnt_q[i] <= '0;
      end
      sw_out         <= '0;
      sw_rise        <= '0;
      sw_fall        <= '0;
      change_mask    <= '0;
      change_pending <= 1'b0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sw_out         <= sw_out_d;
      sw_rise        <= upd & sw_out_d;
      sw_fall        <= upd & ~sw_out_d;
      change_mask    <= change_mask_d;
      change_pending <= |change_mask_d;
    end
  end

endmodule

// File: tb/tb_gpio_sw_debounce.sv
// Directed bench for gpio_sw_debounce with a short debounce window.
module tb_gpio_sw_debounce;

  localparam int unsigned N_SW = 12;

  logic            clk;
  logic            rst_n;
  logic [N_SW-1:0] sw_in;
  logic [N_SW-1:0] sw_out;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;
  logic            change_pending;
  logic [N_SW-1:0] change_mask;
  logic            change_ack;

  int n_checks = 0;
  int n_errors = 0;

  gpio_sw_debounce #(
    .N_SW       (N_SW),
    .SYNC_STAGES(2),
    .DEB_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sw_in         (sw_in),
    .sw_out        (sw_out),
    .sw_rise       (sw_rise),
    .sw_fall       (sw_fall),
    .change_pending(change_pending),
    .change_mask   (change_mask),
    .change_ack    (change_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past n rising edges; returns 1 ns after the last one.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_once();
    change_ack = 1'b1;
    step(1);
    change_ack = 1'b0;
  endtask

  logic [N_SW-1:0] rise_acc;
  logic [N_SW-1:0] fall_acc;
  int              n_pulses;
  int              pulse_edge;

  initial begin
    rst_n      = 1'b0;
    sw_in      = '0;
    change_ack = 1'b0;
    step(2);
    check_eq("reset_sw_out", 32'(sw_out), 32'h0);
    check_eq("reset_pending", 32'(change_pending), 32'h0);
    check_eq("reset_mask", 32'(change_mask), 32'h0);
    rst_n = 1'b1;
    step(2);

    // Clean step on bit 0.
    sw_in = 12'h001;
    step(5);
    check_eq("step_not_yet", 32'(sw_out), 32'h000);
    step(1);
    check_eq("step_sw_out", 32'(sw_out), 32'h001);
    check_eq("step_rise", 32'(sw_rise), 32'h001);
    check_eq("step_pending", 32'(change_pending), 32'h1);
    check_eq("step_mask", 32'(change_mask), 32'h001);
    step(1);
    check_eq("step_rise_gone", 32'(sw_rise), 32'h000);

    // Ack in the same cycle that bit 7 updates.
    sw_in = 12'h081;
    step(5);
    change_ack = 1'b1;
    step(1);
    change_ack = 1'b0;
    check_eq("race_sw_out", 32'(sw_out), 32'h081);
    check_eq("race_mask", 32'(change_mask), 32'h080);
    check_eq("race_pending", 32'(change_pending), 32'h1);
    ack_once();
    check_eq("ack2_mask", 32'(change_mask), 32'h000);
    check_eq("ack2_pending", 32'(change_pending), 32'h0);
    ack_once();
    check_eq("idle_ack_pending", 32'(change_pending), 32'h0);

    // Three-cycle glitch on bit 3 is rejected.
    rise_acc = '0;
    sw_in    = 12'h089;
    step(3);
    sw_in = 12'h081;
    for (int k = 0; k < 10; k++) begin
      step(1);
      rise_acc |= sw_rise;
    end
    check_eq("glitch3_sw_out", 32'(sw_out), 32'h081);
    check_eq("glitch3_rise", 32'(rise_acc), 32'h000);
    check_eq("glitch3_pending", 32'(change_pending), 32'h0);

    // Four-cycle pulse on bit 3 is accepted at edge 6.
    sw_in = 12'h089;
    step(4);
    sw_in = 12'h081;
    step(1);
    check_eq("glitch4_not_yet", 32'(sw_out), 32'h081);
    step(1);
    check_eq("glitch4_sw_out", 32'(sw_out), 32'h089);
    check_eq("glitch4_rise", 32'(sw_rise), 32'h008);
    step(10);
    check_eq("glitch4_back", 32'(sw_out), 32'h081);
    ack_once();

    // Bounce on bit 5: 1,0,1,0 then hold 1.
    sw_in = 12'h0A1; step(1);
    sw_in = 12'h081; step(1);
    sw_in = 12'h0A1; step(1);
    sw_in = 12'h081; step(1);
    check_eq("bounce_no_early", 32'(sw_rise), 32'h000);
    sw_in      = 12'h0A1;
    n_pulses   = 0;
    pulse_edge = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (sw_rise[5]) begin
        n_pulses++;
        pulse_edge = k;
      end
    end
    check_eq("bounce_pulses", 32'(n_pulses), 32'd1);
    check_eq("bounce_edge", 32'(pulse_edge), 32'd6);
    check_eq("bounce_sw_out", 32'(sw_out), 32'h0A1);
    ack_once();

    // All high, then fall on multiple bits together.
    sw_in = 12'hFFF;
    step(6);
    check_eq("all_high", 32'(sw_out), 32'hFFF);
    step(1);
    ack_once();
    check_eq("all_high_acked", 32'(change_mask), 32'h000);
    sw_in    = 12'h0F0;
    fall_acc = '0;
    step(5);
    check_eq("fall_not_yet", 32'(sw_fall), 32'h000);
    step(1);
    check_eq("fall_pulse", 32'(sw_fall), 32'hF0F);
    check_eq("fall_no_rise", 32'(sw_rise), 32'h000);
    check_eq("fall_sw_out", 32'(sw_out), 32'h0F0);
    check_eq("fall_mask", 32'(change_mask), 32'hF0F);
    step(1);
    check_eq("fall_pulse_gone", 32'(sw_fall), 32'h000);
    ack_once();

    // Reset part-way through a pending change on bit 0.
    sw_in = 12'h0F1;
    step(4);
    rst_n = 1'b0;
    #1;
    check_eq("rst_sw_out", 32'(sw_out), 32'h000);
    check_eq("rst_pending", 32'(change_pending), 32'h0);
    check_eq("rst_mask", 32'(change_mask), 32'h000);
    sw_in = 12'h800;
    step(1);
    rst_n = 1'b1;
    n_pulses   = 0;
    pulse_edge = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (sw_rise != '0) begin
        n_pulses++;
        pulse_edge = k;
        check_eq("rst_rise_val", 32'(sw_rise), 32'h800);
      end
      if (k == 5) check_eq("rst_not_yet", 32'(sw_out), 32'h000);
      if (k == 6) begin
        check_eq("rst_sw_out_after", 32'(sw_out), 32'h800);
        check_eq("rst_pending_after", 32'(change_pending), 32'h1);
      end
    end
    check_eq("rst_pulses", 32'(n_pulses), 32'd1);
    check_eq("rst_pulse_edge", 32'(pulse_edge), 32'd6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
